// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller:
// FSM state encoding, comparator flag bundle and a one-hot test on the flags.
package sar_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } sar_state_e;

  typedef struct packed {
    logic l;
    logic e;
    logic s;
  } sar_flags_t;

  // Exactly one flag set: odd population that is not all three.
  function automatic logic flags_onehot(input sar_flags_t f);
    return (f.l ^ f.e ^ f.s) & ~(f.l & f.e & f.s);
  endfunction

endpackage

// File: rtl/sar_step.sv
// Combinational decode of one search step: from the current probe, bit index
// and comparator flags, produce the next probe or the terminating result.
module sar_step
  import sar_pkg::*;
#(
  parameter int W  = 4,
  parameter int KW = $clog2(W)
) (
  input  logic [W-1:0]  i_probe,
  input  logic [KW-1:0] i_k,
  input  sar_flags_t    i_flags,
  input  logic          i_flag_err,
  output logic [W-1:0]  o_next_probe,
  output logic          o_finish,
  output logic [W-1:0]  o_result,
  output logic          o_exact
);

  logic [W-1:0] w_one;
  logic [W-1:0] w_bit_k;
  logic [W-1:0] w_bit_km1;
  logic [W-1:0] w_cleared;
  logic         w_last;

  assign w_one     = {{(W-1){1'b0}}, 1'b1};
  assign w_bit_k   = w_one << i_k;
  // Shifting right by one yields zero at k==0, where it is never used anyway.
  assign w_bit_km1 = w_bit_k >> 1;
  assign w_cleared = i_probe & ~w_bit_k;
  assign w_last    = (i_k == {KW{1'b0}});

  // Flag decode in priority order: protocol error, E, L, then S (also no flag).
  always_comb begin
    o_next_probe = i_probe;
    o_finish     = 1'b0;
    o_result     = i_probe;
    o_exact      = 1'b0;
    if (i_flag_err) begin
      o_finish = 1'b1;
    end else if (i_flags.e) begin
      o_finish = 1'b1;
      o_exact  = 1'b1;
    end else if (i_flags.l) begin
      if (w_last) begin
        o_finish = 1'b1;
      end else begin
        o_next_probe = i_probe | w_bit_km1;
      end
    end else begin
      if (w_last) begin
        o_finish = 1'b1;
        o_result = w_cleared;
      end else begin
        o_next_probe = w_cleared | w_bit_km1;
      end
    end
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller driving a magnitude comparator.
// Optional macro SAR_ONEHOT_CHK_EN enables the one-hot check on L/E/S (err).
module sar_search
  import sar_pkg::*;
#(
  parameter  int W  = 4,
  localparam int KW = $clog2(W),
  localparam int SW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          L,
  input  logic          E,
  input  logic          S,
  output logic [W-1:0]  probe,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          exact,
  output logic [SW-1:0] steps,
  output logic          err
);

  localparam logic [W-1:0]  PROBE_MSB = {1'b1, {(W-1){1'b0}}};
  localparam logic [KW-1:0] K_TOP     = KW'(W - 1);
  localparam logic [KW-1:0] K_ONE     = KW'(1);
  localparam logic [SW-1:0] CNT_ONE   = SW'(1);

  sar_state_e    r_state;
  sar_state_e    w_state_nxt;
  logic [W-1:0]  r_probe,  w_probe_nxt;
  logic [KW-1:0] r_k,      w_k_nxt;
  logic [SW-1:0] r_cnt,    w_cnt_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_done,   w_done_nxt;
  logic [W-1:0]  r_result, w_result_nxt;
  logic          r_exact,  w_exact_nxt;
  logic [SW-1:0] r_steps,  w_steps_nxt;
  logic          r_err,    w_err_nxt;

  sar_flags_t    w_flags;
  logic          w_flag_err;
  logic [W-1:0]  w_step_probe;
  logic          w_step_finish;
  logic [W-1:0]  w_step_result;
  logic          w_step_exact;

  assign w_flags = {L, E, S};

`ifdef SAR_ONEHOT_CHK_EN
  assign w_flag_err = ~flags_onehot(w_flags);
`else
  assign w_flag_err = 1'b0;
`endif

  sar_step #(.W(W), .KW(KW)) u_step (
    .i_probe      (r_probe),
    .i_k          (r_k),
    .i_flags      (w_flags),
    .i_flag_err   (w_flag_err),
    .o_next_probe (w_step_probe),
    .o_finish     (w_step_finish),
    .o_result     (w_step_result),
    .o_exact      (w_step_exact)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start in IDLE wins over a simultaneous abort.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEARCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (abort || w_step_finish) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; results only move on a completed search.
  always_comb begin
    w_probe_nxt  = r_probe;
    w_k_nxt      = r_k;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_exact_nxt  = r_exact;
    w_steps_nxt  = r_steps;
    w_err_nxt    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_probe_nxt = PROBE_MSB;
          w_k_nxt     = K_TOP;
          w_cnt_nxt   = {SW{1'b0}};
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_SEARCH: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (abort) begin
          w_probe_nxt = {W{1'b0}};
          w_busy_nxt  = 1'b0;
        end else if (w_step_finish) begin
          w_probe_nxt  = {W{1'b0}};
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = w_step_result;
          w_exact_nxt  = w_step_exact;
          w_steps_nxt  = r_cnt + CNT_ONE;
          w_err_nxt    = r_err | w_flag_err;
        end else begin
          w_probe_nxt = w_step_probe;
          w_k_nxt     = r_k - K_ONE;
        end
      end
      default: begin
        w_probe_nxt = {W{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_probe  <= {W{1'b0}};
      r_k      <= {KW{1'b0}};
      r_cnt    <= {SW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {W{1'b0}};
      r_exact  <= 1'b0;
      r_steps  <= {SW{1'b0}};
      r_err    <= 1'b0;
    end else begin
      r_probe  <= w_probe_nxt;
      r_k      <= w_k_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_exact  <= w_exact_nxt;
      r_steps  <= w_steps_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign probe  = r_probe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign exact  = r_exact;
  assign steps  = r_steps;
  assign err    = r_err;

endmodule
